// File: rtl/seletor_mapa_gen.sv
// Map selector: browse a table of preset maps, preview with optional mirroring,
// and commit the preview into a locked game map until unlocked.
module seletor_mapa_gen #(
    parameter int unsigned LINHAS    = 5,
    parameter int unsigned COLUNAS   = 7,
    parameter int unsigned NUM_MAPAS = 8,
    parameter logic [NUM_MAPAS*LINHAS*COLUNAS-1:0] MAPAS_INIT = '0,
    localparam int unsigned MAP_W = LINHAS * COLUNAS,
    localparam int unsigned IDX_W = (NUM_MAPAS > 1) ? $clog2(NUM_MAPAS) : 1,
    localparam int unsigned CNT_W = $clog2(MAP_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             btn_prox,
    input  logic             btn_ant,
    input  logic             confirmar,
    input  logic             desbloquear,
    input  logic             espelhar,
    output logic [IDX_W-1:0] indice,
    output logic [MAP_W-1:0] mapa_temp,
    output logic [MAP_W-1:0] mapa,
    output logic [CNT_W-1:0] celulas,
    output logic             travado,
    output logic             pronto
);

    typedef enum logic {
        ESCOLHA = 1'b0,
        TRAVADO = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_MAPAS - 1);

    state_t           state, state_next;
    logic [IDX_W-1:0] indice_next;
    logic [MAP_W-1:0] mapa_next;
    logic             pronto_next;

    logic hist_prox, hist_ant, hist_conf, hist_desb;
    logic ev_prox, ev_ant, ev_conf, ev_desb;
    logic [MAP_W-1:0] preset;

    // Histories reset high so inputs held through reset never produce an event.
    assign ev_prox = btn_prox    & ~hist_prox;
    assign ev_ant  = btn_ant     & ~hist_ant;
    assign ev_conf = confirmar   & ~hist_conf;
    assign ev_desb = desbloquear & ~hist_desb;

    // Preview: select the browsed preset and mirror each row on request.
    always_comb begin
        preset    = MAPAS_INIT[32'(indice) * MAP_W +: MAP_W];
        mapa_temp = '0;
        for (int unsigned r = 0; r < LINHAS; r++) begin
            for (int unsigned c = 0; c < COLUNAS; c++) begin
                mapa_temp[r*COLUNAS + c] = espelhar ? preset[r*COLUNAS + (COLUNAS - 1 - c)]
                                                    : preset[r*COLUNAS + c];
            end
        end
    end

    always_comb begin
        celulas = '0;
        for (int unsigned i = 0; i < MAP_W; i++) begin
            celulas = celulas + CNT_W'(mapa_temp[i]);
        end
    end

    always_comb begin
        state_next  = state;
        indice_next = indice;
        mapa_next   = mapa;
        pronto_next = 1'b0;
        case (state)
            ESCOLHA: begin
                if (ev_prox && !ev_ant) begin
                    indice_next = (indice == IDX_MAX) ? '0 : indice + IDX_W'(1);
                end else if (ev_ant && !ev_prox) begin
                    indice_next = (indice == '0) ? IDX_MAX : indice - IDX_W'(1);
                end
                // The commit captures the preview seen before this edge.
                if (ev_conf && enable) begin
                    mapa_next   = mapa_temp;
                    pronto_next = 1'b1;
                    state_next  = TRAVADO;
                end
            end
            TRAVADO: begin
                if (ev_desb) begin
                    state_next = ESCOLHA;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ESCOLHA;
            indice    <= '0;
            mapa      <= '0;
            pronto    <= 1'b0;
            hist_prox <= 1'b1;
            hist_ant  <= 1'b1;
            hist_conf <= 1'b1;
            hist_desb <= 1'b1;
        end else begin
            state     <= state_next;
            indice    <= indice_next;
            mapa      <= mapa_next;
            pronto    <= pronto_next;
            hist_prox <= btn_prox;
            hist_ant  <= btn_ant;
            hist_conf <= confirmar;
            hist_desb <= desbloquear;
        end
    end

    assign travado = (state == TRAVADO);

endmodule

// File: doc/seletor_mapa_gen.md
SELETOR_MAPA_GEN -- requirements
Module: seletor_mapa_gen

Interface
REQ-001 Parameter LINHAS, default 5: number of map rows.
REQ-002 Parameter COLUNAS, default 7: number of cells per row.
REQ-003 Parameter NUM_MAPAS, default 8: preset map count; legal range 2..256.
REQ-004 Parameter MAPAS_INIT, width NUM_MAPAS*LINHAS*COLUNAS, default all-zero: preset table. Map m at bits [m*LINHAS*COLUNAS +: LINHAS*COLUNAS]. Row r at offset r*COLUNAS. Column c at bit c of its row.
REQ-005 Derived IDX_W = max(1, clog2(NUM_MAPAS)); CNT_W = clog2(LINHAS*COLUNAS+1).
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 enable  input  1  permits confirmation; level.
REQ-009 btn_prox  input  1  next-map request; level, rising-edge detected internally.
REQ-010 btn_ant  input  1  previous-map request; level, rising-edge detected internally.
REQ-011 confirmar  input  1  confirm request; level, rising-edge detected internally.
REQ-012 desbloquear  input  1  unlock request; level, rising-edge detected internally.
REQ-013 espelhar  input  1  mirror mode; level, applied combinationally to mapa_temp.
REQ-014 indice  output  IDX_W  currently browsed map index.
REQ-015 mapa_temp  output  LINHAS*COLUNAS  preview of browsed map, mirror applied.
REQ-016 mapa  output  LINHAS*COLUNAS  committed game map.
REQ-017 celulas  output  CNT_W  number of 1-bits in mapa_temp.
REQ-018 travado  output  1  high while in state TRAVADO.
REQ-019 pronto  output  1  one-cycle pulse on each commit.

Function
REQ-020 Each of btn_prox, btn_ant, confirmar and desbloquear is sampled into a 1-bit history register every clock. An event is input=1 while history=0. The event acts on that same clock edge.
REQ-021 The FSM has two states: ESCOLHA (browsing) and TRAVADO (locked).
REQ-022 ESCOLHA, prox event only: indice <= indice+1. indice wraps from NUM_MAPAS-1 to 0.
REQ-023 ESCOLHA, ant event only: indice <= indice-1. indice wraps from 0 to NUM_MAPAS-1.
REQ-024 Simultaneous prox and ant events: indice is unchanged.
REQ-025 ESCOLHA, confirmar event with enable=1: mapa <= mapa_temp as presented before this edge. The FSM moves to TRAVADO and pronto=1 for exactly the next cycle.
REQ-026 A confirmar event coincident with a nav event commits the pre-update preview. indice still updates.
REQ-027 A confirmar event with enable=0 is discarded; it is not remembered for later.
REQ-028 TRAVADO: nav and confirmar events are ignored, and indice and mapa hold.
REQ-029 TRAVADO, desbloquear event: return to ESCOLHA. mapa and indice are retained.
REQ-030 A desbloquear event in ESCOLHA has no effect.
REQ-031 mapa_temp row r, column c = preset[indice] row r, column (espelhar ? COLUNAS-1-c : c). This path is combinational and has zero latency.
REQ-032 celulas = popcount of mapa_temp, combinational, computed at full CNT_W width with no overflow.
REQ-033 An out-of-range indice cannot occur; a non-power-of-2 NUM_MAPAS wraps per REQ-022/023.

Reset
REQ-034 While rst_n=0: indice=0, mapa=0, state=ESCOLHA, travado=0, pronto=0, and all edge-history registers=1.
REQ-035 Because the history registers reset to 1, an input already held high through reset does not create an event.
REQ-036 Reset asserted mid-operation, including in TRAVADO or during a pronto pulse, forces the REQ-034 values immediately, without waiting for a clock.

Verification
(Bench parameters: LINHAS=2, COLUNAS=3, NUM_MAPAS=3, MAPAS_INIT=18'h141F1. This gives map0=6'b110001, map1=6'b000111, map2=6'b010100.)
REQ-037 Release reset, idle -> indice=0, mapa_temp=6'b110001, celulas=3, mapa=0, travado=0.
REQ-038 Three prox pulses -> indice 1, 2, 0. Then one ant pulse -> indice=2, mapa_temp=6'b010100, celulas=2.
REQ-039 At indice=0, set espelhar=1 -> mapa_temp=6'b011100 in the same cycle. Confirm with enable=1 -> mapa=6'b011100, pronto high for one cycle, travado=1.
REQ-040 In TRAVADO, pulse prox and confirmar -> indice and mapa unchanged. Pulse desbloquear -> travado=0. Prox -> indice=1, and mapa still 6'b011100.
REQ-041 enable=0, confirm at indice=1 -> mapa unchanged, pronto stays 0. Raise enable=1 with confirmar still high -> no commit. Release and re-press -> mapa=6'b000111.
REQ-042 Same-cycle prox+ant -> indice holds. Same-cycle confirm+prox at indice=2 -> mapa=6'b010100, indice=0. Assert rst_n=0 between clock edges -> mapa=0 and travado=0 immediately.
